// File: rtl/channel_xbar.sv
// channel_xbar - S-source to D-destination channel crossbar, one instance per AXI channel.
// Optional packet lock per destination is enabled by defining CHANNEL_XBAR_LOCK_EN;
// without it every beat is arbitrated on its own and srcLast_i is only forwarded.

// xbarFifo: generic synchronous FIFO used as the per-destination output buffer.
// Latency: an entry pushed into an empty FIFO is at the head right after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module xbarFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushDat,
    input  logic             pop,
    output logic [WIDTH-1:0] headDat,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wrPtr;
    logic [PW-1:0]               rdPtr;
    logic                        doPush;
    logic                        doPop;

    function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    assign doPush  = push && ((count != CW'(DEPTH)) || doPop);
    assign headDat = mem[rdPtr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem   <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushDat;
                wrPtr      <= ptrNext(wrPtr);
            end
            if (doPop) begin
                rdPtr <= ptrNext(rdPtr);
            end
            if (doPush && !doPop) begin
                count <= count + CW'(1);
            end else if (doPop && !doPush) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// channel_xbar: per-destination round-robin arbitration feeding a 2-entry output buffer.
// Latency: a beat accepted at edge N is presented on the destination after edge N.
// Backpressure: srcRdy_o drops only when the destination buffer is full and not draining.
module channel_xbar #(
    parameter int S     = 2,
    parameter int D     = 2,
    parameter int WIDTH = 64,
    parameter int LOG_S = (S > 1) ? $clog2(S) : 1,
    parameter int LOG_D = (D > 1) ? $clog2(D) : 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [S-1:0]                srcVld_i,
    input  logic [S-1:0][LOG_D-1:0]     srcTarget_i,
    input  logic [S-1:0][WIDTH-1:0]     srcDat_i,
    input  logic [S-1:0]                srcLast_i,
    output logic [S-1:0]                srcRdy_o,
    input  logic [D-1:0]                dstRdy_i,
    output logic [D-1:0]                dstVld_o,
    output logic [D-1:0][WIDTH-1:0]     dstDat_o,
    output logic [D-1:0][LOG_S-1:0]     dstSrc_o,
    output logic [D-1:0]                dstLast_o,
    output logic                        errBadTgt_o
);
    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [LOG_S-1:0] src;
        logic             last;
    } beat_t;

    logic [D-1:0][S-1:0]     req;
    logic [D-1:0][S-1:0]     eligible;
    logic [D-1:0][S-1:0]     grant;
    logic [D-1:0][LOG_S-1:0] winner;
    logic [D-1:0]            found;
    logic [D-1:0]            space;
    logic [D-1:0]            accept;
    logic [D-1:0]            popEn;
    logic [D-1:0]            fifoEmpty;
    logic [D-1:0][1:0]       fifoCnt;
    logic [D-1:0][LOG_S-1:0] rrPtr;
    beat_t [D-1:0]           pushBeat;
    beat_t [D-1:0]           headBeat;
    logic                    badTgt;

    function automatic logic [LOG_S-1:0] rrNext(input logic [LOG_S-1:0] w);
        return (int'(w) == S - 1) ? '0 : w + LOG_S'(1);
    endfunction

    // Decode each valid source into a request on its target; out-of-range targets request nothing
    always_comb begin
        req    = '0;
        badTgt = 1'b0;
        for (int s = 0; s < S; s++) begin
            if (srcVld_i[s]) begin
                if (int'(srcTarget_i[s]) >= D) begin
                    badTgt = 1'b1;
                end
                for (int d = 0; d < D; d++) begin
                    if (int'(srcTarget_i[s]) == d) begin
                        req[d][s] = 1'b1;
                    end
                end
            end
        end
    end

`ifdef CHANNEL_XBAR_LOCK_EN
    logic [D-1:0]            lockVld;
    logic [D-1:0][LOG_S-1:0] lockSrc;

    // A locked destination only listens to the source that owns the open packet
    always_comb begin
        eligible = req;
        for (int d = 0; d < D; d++) begin
            if (lockVld[d]) begin
                for (int s = 0; s < S; s++) begin
                    if (s != int'(lockSrc[d])) begin
                        eligible[d][s] = 1'b0;
                    end
                end
            end
        end
    end
`else
    assign eligible = req;
`endif

    // Round-robin pick per destination: first eligible source starting at rrPtr
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = '0;
        for (int d = 0; d < D; d++) begin
            for (int k = 0; k < S; k++) begin
                int idx;
                idx = int'(rrPtr[d]) + k;
                if (idx >= S) begin
                    idx = idx - S;
                end
                if (!found[d] && eligible[d][idx]) begin
                    found[d]      = 1'b1;
                    grant[d][idx] = 1'b1;
                    winner[d]     = LOG_S'(idx);
                end
            end
        end
    end

    // Buffer space includes a full buffer that drains this cycle; a beat moves on grant and space
    always_comb begin
        for (int d = 0; d < D; d++) begin
            space[d]    = (fifoCnt[d] < 2'd2) || ((fifoCnt[d] == 2'd2) && dstRdy_i[d]);
            accept[d]   = found[d] && space[d];
            popEn[d]    = dstVld_o[d] && dstRdy_i[d];
            pushBeat[d] = '{dat: srcDat_i[winner[d]], src: winner[d], last: srcLast_i[winner[d]]};
        end
    end

    // Each source targets one destination, so its ready is the OR of its grants with space
    always_comb begin
        srcRdy_o = '0;
        for (int d = 0; d < D; d++) begin
            for (int s = 0; s < S; s++) begin
                if (grant[d][s] && space[d]) begin
                    srcRdy_o[s] = 1'b1;
                end
            end
        end
        if (!rstn) begin
            srcRdy_o = '0;
        end
    end

    // Pointer moves past the winner on every accepted beat, or only on the last beat under lock
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rrPtr <= '0;
`ifdef CHANNEL_XBAR_LOCK_EN
            lockVld <= '0;
            lockSrc <= '0;
`endif
        end else begin
            for (int d = 0; d < D; d++) begin
                if (accept[d]) begin
`ifdef CHANNEL_XBAR_LOCK_EN
                    if (pushBeat[d].last) begin
                        lockVld[d] <= 1'b0;
                        rrPtr[d]   <= rrNext(winner[d]);
                    end else begin
                        lockVld[d] <= 1'b1;
                        lockSrc[d] <= winner[d];
                    end
`else
                    rrPtr[d] <= rrNext(winner[d]);
`endif
                end
            end
        end
    end

    // Sticky error once any valid beat names a destination that does not exist
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            errBadTgt_o <= 1'b0;
        end else if (badTgt) begin
            errBadTgt_o <= 1'b1;
        end
    end

    for (genvar d = 0; d < D; d++) begin : gDst
        xbarFifo #(
            .WIDTH ($bits(beat_t)),
            .DEPTH (2)
        ) uBuf (
            .clk     (clk),
            .rstn    (rstn),
            .push    (accept[d]),
            .pushDat (pushBeat[d]),
            .pop     (popEn[d]),
            .headDat (headBeat[d]),
            .empty   (fifoEmpty[d]),
            .count   (fifoCnt[d])
        );
        assign dstVld_o[d]  = !fifoEmpty[d];
        assign dstDat_o[d]  = headBeat[d].dat;
        assign dstSrc_o[d]  = headBeat[d].src;
        assign dstLast_o[d] = headBeat[d].last;
    end
endmodule

// File: tb/tb_channel_xbar.sv
// tb_channel_xbar - S=4, D=3 crossbar bench: directed vectors plus randomized traffic
// checked every cycle against a queue-based model of the crossbar rules.
// Lock-dependent expectations follow CHANNEL_XBAR_LOCK_EN.
module tb_channel_xbar;
    localparam int S  = 4;
    localparam int D  = 3;
    localparam int W  = 16;
    localparam int LS = 2;
    localparam int LD = 2;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [S-1:0]           srcVld, srcLast, srcRdy;
    logic [S-1:0][LD-1:0]   srcTarget;
    logic [S-1:0][W-1:0]    srcDat;
    logic [D-1:0]           dstRdy, dstVld, dstLast;
    logic [D-1:0][W-1:0]    dstDat;
    logic [D-1:0][LS-1:0]   dstSrc;
    logic                   errBadTgt;

    channel_xbar #(.S(S), .D(D), .WIDTH(W), .LOG_S(LS), .LOG_D(LD)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .srcVld_i    (srcVld),
        .srcTarget_i (srcTarget),
        .srcDat_i    (srcDat),
        .srcLast_i   (srcLast),
        .srcRdy_o    (srcRdy),
        .dstRdy_i    (dstRdy),
        .dstVld_o    (dstVld),
        .dstDat_o    (dstDat),
        .dstSrc_o    (dstSrc),
        .dstLast_o   (dstLast),
        .errBadTgt_o (errBadTgt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: per-destination queues, pointers and locks
    typedef struct packed {
        logic [W-1:0]  dat;
        logic [LS-1:0] src;
        logic          last;
    } mbeat_t;
    mbeat_t mq[D][$];
    int     rr[D];
    bit     mErr;
`ifdef CHANNEL_XBAR_LOCK_EN
    bit     lockV[D];
    int     lockS[D];
`endif

    // observed DUT values at the most recent negedge
    logic [S-1:0]         obsRdy;
    logic [D-1:0]         obsVld;
    logic [D-1:0][W-1:0]  obsDat;
    logic [D-1:0][LS-1:0] obsSrc;
    logic                 obsErr;

    task automatic modelReset();
        for (int d = 0; d < D; d++) begin
            mq[d].delete();
            rr[d] = 0;
`ifdef CHANNEL_XBAR_LOCK_EN
            lockV[d] = 0;
            lockS[d] = 0;
`endif
        end
        mErr = 0;
    endtask

    // One clock: compare DUT against model at negedge, advance model, return at posedge+1
    task automatic cycle();
        int           win[D];
        logic [S-1:0] expRdy;
        bit           sp;
        bit           elig;
        int           s;
        @(negedge clk);
        obsRdy = srcRdy; obsVld = dstVld; obsDat = dstDat; obsSrc = dstSrc; obsErr = errBadTgt;
        expRdy = '0;
        for (int d = 0; d < D; d++) begin
            win[d] = -1;
            sp = (mq[d].size() < 2) || (mq[d].size() == 2 && dstRdy[d]);
            for (int k = 0; k < S; k++) begin
                s = (rr[d] + k) % S;
                elig = srcVld[s] && (int'(srcTarget[s]) == d);
`ifdef CHANNEL_XBAR_LOCK_EN
                if (lockV[d] && lockS[d] != s) elig = 0;
`endif
                if (win[d] < 0 && elig) win[d] = s;
            end
            if (win[d] >= 0 && sp) expRdy[win[d]] = 1'b1;
            else win[d] = -1;
        end
        chk("srcRdy", 32'(srcRdy), 32'(expRdy));
        chk("errBadTgt", 32'(errBadTgt), 32'(mErr));
        for (int d = 0; d < D; d++) begin
            chk($sformatf("dstVld%0d", d), 32'(dstVld[d]), 32'(mq[d].size() > 0));
            if (mq[d].size() > 0) begin
                chk($sformatf("dstDat%0d", d), 32'(dstDat[d]), 32'(mq[d][0].dat));
                chk($sformatf("dstSrc%0d", d), 32'(dstSrc[d]), 32'(mq[d][0].src));
                chk($sformatf("dstLast%0d", d), 32'(dstLast[d]), 32'(mq[d][0].last));
            end
        end
        for (int d = 0; d < D; d++) begin
            if (mq[d].size() > 0 && dstRdy[d]) void'(mq[d].pop_front());
            if (win[d] >= 0) begin
                mq[d].push_back('{dat: srcDat[win[d]], src: LS'(win[d]), last: srcLast[win[d]]});
`ifdef CHANNEL_XBAR_LOCK_EN
                if (srcLast[win[d]]) begin
                    lockV[d] = 0;
                    rr[d] = (win[d] + 1) % S;
                end else begin
                    lockV[d] = 1;
                    lockS[d] = win[d];
                end
`else
                rr[d] = (win[d] + 1) % S;
`endif
            end
        end
        for (int i = 0; i < S; i++) begin
            if (srcVld[i] && int'(srcTarget[i]) >= D) mErr = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_dstVld"}, 32'(dstVld), 32'h0);
        chk({tag, "_dstDat"}, 32'(dstDat[0] | dstDat[1] | dstDat[2]), 32'h0);
        chk({tag, "_dstSrc"}, 32'(dstSrc), 32'h0);
        chk({tag, "_dstLast"}, 32'(dstLast), 32'h0);
        chk({tag, "_srcRdy"}, 32'(srcRdy), 32'h0);
        chk({tag, "_err"}, 32'(errBadTgt), 32'h0);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        srcVld = '0; srcLast = '0; srcTarget = '0; srcDat = '0; dstRdy = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chkResetOutputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [S-1:0]         vld;
        logic [S-1:0][LD-1:0] tgt;
        logic [D-1:0]         rdy;
        logic [S-1:0]         expRdy;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   b0;
        bit   s1done;
        int   idx;
        int   gotS[8];
        int   gotD[8];
        int   gotC[8];
        int   expS[4];
        int   expD[4];
        int   expR[3];
        logic [S-1:0]  busy;
        bit            inPkt[S];
        logic [LD-1:0] pktTgt[S];

        // round-robin vectors: all four sources valid to d0, single-beat packets
        tbl[0] = '{4'hF, 8'h00, 3'b111, 4'b0001};
        tbl[1] = '{4'hF, 8'h00, 3'b111, 4'b0010};
        tbl[2] = '{4'hF, 8'h00, 3'b111, 4'b0100};
        tbl[3] = '{4'hF, 8'h00, 3'b111, 4'b1000};
        tbl[4] = '{4'hF, 8'h00, 3'b111, 4'b0001};
        tbl[5] = '{4'hF, 8'h00, 3'b111, 4'b0010};
        tbl[6] = '{4'hF, 8'h00, 3'b111, 4'b0100};
        tbl[7] = '{4'hF, 8'h00, 3'b111, 4'b1000};

        // two sources to two different destinations in the same cycle
        doReset();
        dstRdy = 3'b111;
        srcVld = 4'b0011; srcLast = 4'hF;
        srcTarget[0] = 2'd1; srcDat[0] = 16'h000A;
        srcTarget[1] = 2'd0; srcDat[1] = 16'h000B;
        cycle();
        chk("parallel_rdy", 32'(obsRdy), 32'b0011);
        srcVld = '0;
        cycle();
        chk("parallel_vld", 32'(obsVld), 32'b011);
        chk("parallel_dat1", 32'(obsDat[1]), 32'h000A);
        chk("parallel_src1", 32'(obsSrc[1]), 32'd0);
        chk("parallel_dat0", 32'(obsDat[0]), 32'h000B);
        chk("parallel_src0", 32'(obsSrc[0]), 32'd1);

        // round-robin table
        doReset();
        for (int s = 0; s < S; s++) srcDat[s] = 16'(16'h10 + s);
        srcLast = 4'hF;
        for (int i = 0; i < 8; i++) begin
            srcVld = tbl[i].vld; srcTarget = tbl[i].tgt; dstRdy = tbl[i].rdy;
            cycle();
            chk($sformatf("rr_rdy%0d", i), 32'(obsRdy), 32'(tbl[i].expRdy));
            if (i > 0) chk($sformatf("rr_src%0d", i), 32'(obsSrc[0]), 32'((i - 1) % 4));
        end

        // 3-beat packet from src0 competing with a single beat from src1
        doReset();
        dstRdy = 3'b111;
        b0 = 0; s1done = 0; n = 0;
`ifdef CHANNEL_XBAR_LOCK_EN
        expS = '{0, 0, 0, 1}; expD = '{1, 2, 3, 'h55};
`else
        expS = '{0, 1, 0, 0}; expD = '{1, 'h55, 2, 3};
`endif
        for (int c = 0; c < 10; c++) begin
            srcVld[0] = (b0 < 3); srcTarget[0] = 2'd0; srcDat[0] = 16'(b0 + 1); srcLast[0] = (b0 == 2);
            srcVld[1] = !s1done;  srcTarget[1] = 2'd0; srcDat[1] = 16'h0055;    srcLast[1] = 1'b1;
            cycle();
            if (obsVld[0] && n < 8) begin
                gotS[n] = int'(obsSrc[0]); gotD[n] = int'(obsDat[0]); n++;
            end
            if (obsRdy[0]) b0++;
            if (obsRdy[1]) s1done = 1;
        end
        chk("lock_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lock_src%0d", i), 32'(gotS[i]), 32'(expS[i]));
            chk($sformatf("lock_dat%0d", i), 32'(gotD[i]), 32'(expD[i]));
        end

        // backpressure: two beats fill d0, third stalls until dstRdy rises
        doReset();
        srcVld = '0;
        dstRdy = 3'b110; idx = 0;
        expR = '{1, 1, 0};
        for (int c = 0; c < 3; c++) begin
            srcVld[0] = 1'b1; srcTarget[0] = 2'd0; srcDat[0] = 16'(idx + 1); srcLast[0] = 1'b1;
            cycle();
            chk($sformatf("bp_rdy%0d", c), 32'(obsRdy[0]), 32'(expR[c]));
            if (obsRdy[0]) idx++;
        end
        dstRdy = 3'b111; n = 0;
        for (int c = 0; c < 8; c++) begin
            srcVld[0] = (idx < 3); srcDat[0] = 16'(idx + 1);
            cycle();
            if (c == 0) chk("bp_rdy_drain", 32'(obsRdy[0]), 32'd1);
            if (obsVld[0] && n < 8) begin
                gotD[n] = int'(obsDat[0]); gotC[n] = c; n++;
            end
            if (obsRdy[0]) idx++;
        end
        chk("bp_count", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_dat%0d", i), 32'(gotD[i]), 32'(i + 1));
            chk($sformatf("bp_cyc%0d", i), 32'(gotC[i]), 32'(i));
        end

        // out-of-range target
        doReset();
        srcVld = 4'b0001; srcTarget[0] = 2'd3; srcDat[0] = 16'h00EE; srcLast[0] = 1'b1; dstRdy = 3'b111;
        cycle();
        chk("bad_rdy0", 32'(obsRdy[0]), 32'd0);
        chk("bad_err0", 32'(obsErr), 32'd0);
        cycle();
        chk("bad_rdy1", 32'(obsRdy[0]), 32'd0);
        chk("bad_err1", 32'(obsErr), 32'd1);
        srcVld = '0;
        cycle();
        chk("bad_err_sticky", 32'(obsErr), 32'd1);

        // reset with two buffered beats and an open packet
        doReset();
        dstRdy = 3'b110;
        srcVld = 4'b0001; srcTarget[0] = 2'd0; srcDat[0] = 16'h0077; srcLast[0] = 1'b0;
        cycle();
        chk("rst_fill0", 32'(obsRdy[0]), 32'd1);
        cycle();
        chk("rst_fill1", 32'(obsRdy[0]), 32'd1);
        rstn = 1'b0;
        #1;
        chkResetOutputs("midreset");
        modelReset();
        srcVld = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        dstRdy = 3'b111;
        srcVld = 4'b0010; srcTarget[1] = 2'd0; srcDat[1] = 16'h0099; srcLast[1] = 1'b1;
        cycle();
        chk("postrst_rdy", 32'(obsRdy), 32'b0010);
        srcVld = '0;
        cycle();
        chk("postrst_vld", 32'(obsVld[0]), 32'd1);
        chk("postrst_src", 32'(obsSrc[0]), 32'd1);
        chk("postrst_dat", 32'(obsDat[0]), 32'h0099);

        // randomized traffic against the model
        doReset();
        busy = '0;
        for (int s = 0; s < S; s++) begin
            inPkt[s] = 0; pktTgt[s] = '0;
        end
        for (int c = 0; c < 1500; c++) begin
            dstRdy = 3'($urandom_range(0, 7));
            for (int s = 0; s < S; s++) begin
                if (!busy[s]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        busy[s] = 1'b1;
                        srcVld[s] = 1'b1;
                        srcTarget[s] = inPkt[s] ? pktTgt[s] : LD'($urandom_range(0, 2));
                        srcDat[s] = W'($urandom);
                        srcLast[s] = ($urandom_range(0, 2) == 0);
                    end else begin
                        srcVld[s] = 1'b0;
                    end
                end
            end
            cycle();
            for (int s = 0; s < S; s++) begin
                if (srcVld[s] && obsRdy[s]) begin
                    busy[s] = 1'b0;
                    if (srcLast[s]) inPkt[s] = 0;
                    else begin
                        inPkt[s] = 1; pktTgt[s] = srcTarget[s];
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/channel_xbar.md
# channel_xbar

Parametrised S-source to D-destination channel crossbar with an independent round-robin arbiter per destination, so up to min(S,D) beats move per cycle instead of one. Each destination has a 2-entry output buffer, which gives one cycle of latency at full throughput under backpressure. Optional packet lock keeps a destination with one source until that source's last beat. It is the next-generation single-channel switching element of the AXI switch: one instance per AXI channel (AW, W, B, AR, R).

## Interface
Parameters:
- S, 2: number of sources (≥1)
- D, 2: number of destinations (≥1)
- WIDTH, 64: payload width
- LOG_S, (S>1)?$clog2(S):1: source index width
- LOG_D, (D>1)?$clog2(D):1: destination index width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- srcVld_i  in  [S-1:0]  source valid
- srcTarget_i  in  [LOG_D-1:0] x S  destination index per source
- srcDat_i  in  [WIDTH-1:0] x S  payload per source
- srcLast_i  in  [S-1:0]  last beat of packet
- srcRdy_o  out  [S-1:0]  source ready; a beat transfers when srcVld_i & srcRdy_o
- dstRdy_i  in  [D-1:0]  destination ready
- dstVld_o  out  [D-1:0]  destination valid
- dstDat_o  out  [WIDTH-1:0] x D  payload per destination
- dstSrc_o  out  [LOG_S-1:0] x D  source index of the presented beat
- dstLast_o  out  [D-1:0]  last flag of the presented beat
- errBadTgt_o  out  1  sticky flag: a valid beat carried srcTarget_i ≥ D

## Operation
- Requests: req[d][s] = srcVld_i[s] && srcTarget_i[s]==d. Each destination d arbitrates independently.
- Space: space[d] = (buffer count < 2) || (count==2 && dstRdy_i[d]), so a full buffer that drains this cycle can also accept this cycle.
- Grant: the first requester found searching s = rrPtr[d], rrPtr[d]+1, … mod S. srcRdy_o[s] = grant[d][s] && space[d]. srcRdy_o is combinational from srcVld_i/srcTarget_i; srcVld_i never depends on srcRdy_o.
- Pointer: on each accepted beat, rrPtr[d] ← (winner+1) mod S. While a packet lock is active, the pointer is frozen and advances on the last beat.
- Buffer: each destination has a 2-entry FIFO of {dat, src, last}. The head drives dstDat_o/dstSrc_o/dstLast_o, and dstVld_o = not empty. The head pops when dstVld_o && dstRdy_i. Push and pop in the same cycle keep the count.
- Order: beats leave each destination in acceptance order. No beat is duplicated or dropped.
- Out-of-range target (only possible when D is not a power of two): the beat is never granted, srcRdy_o[s] stays 0, and errBadTgt_o is set and held until reset.
- Sources must hold srcTarget_i and srcDat_i stable while valid and not ready. A source must not change target mid-packet; this is not checked.

## Timing
- Reset (rstn low, async): all FIFOs empty; dstVld_o=0, dstDat_o=0, dstSrc_o=0, dstLast_o=0, srcRdy_o=0, errBadTgt_o=0; all rrPtr=0; all locks cleared. Reset mid-packet discards buffered beats and locks with no recovery.
- Latency: a beat accepted at edge N is visible on dstVld_o/dstDat_o after edge N if its buffer was empty.
- Throughput: 1 beat per cycle per destination with dstRdy_i held high. Distinct destinations transfer in the same cycle.
- The 2-entry buffer absorbs one cycle of dstRdy_i deassertion without a bubble.

## Configuration
- CHANNEL_XBAR_LOCK_EN defined: per-destination lock state lockVld[d] and lockSrc[d].
  - Accepting a beat with srcLast_i=0 sets lockVld[d] and lockSrc[d]=winner.
  - While locked, only lockSrc[d] may be granted on d.
  - Accepting a beat with srcLast_i=1 clears the lock and advances rrPtr[d].
- CHANNEL_XBAR_LOCK_EN undefined: arbitration is per beat and no lock state exists. srcLast_i is only forwarded to dstLast_o.

## Test plan
- S=2, D=2; src0→d1 (0xA), src1→d0 (0xB) in the same cycle, dstRdy=11 -> srcRdy_o=11; next cycle dstVld_o=11, dstDat_o[1]=0xA with dstSrc_o[1]=0, dstDat_o[0]=0xB with dstSrc_o[0]=1.
- S=4, all sources valid to d0, single-beat packets, dstRdy=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one beat per cycle.
- LOCK_EN; src0 sends a 3-beat packet (last on beat 3) to d0 while src1 keeps a single beat valid to d0 -> d0 shows src0 beats 1,2,3 back-to-back, then the src1 beat. Without the macro -> src0 and src1 beats alternate.
- dstRdy_i[0]=0, src0 offers 0x1,0x2,0x3 to d0 -> 2 beats accepted, srcRdy_o[0]=0 on the third. Raise dstRdy_i -> 0x1,0x2,0x3 appear in order on consecutive cycles.
- D=3, src0 target=3 valid -> srcRdy_o[0] stays 0; errBadTgt_o=1 from the next cycle and stays 1 after src0 drops valid.
- Reset asserted with 2 beats buffered and a lock active -> all outputs 0 immediately. After release, a new beat from src1 to that destination is granted with no lock interference.
